seg7_scan_ctrl: RTL and testbench

Refresh and update controller sitting directly upstream of the 4-digit seven-segment decoder/driver. It generates the 2-bit digit-scan index and holds the displayed hex value, decimal points and per-digit blank mask in active registers. Game logic writes new display content through a valid/ready port into a one-entry pending buffer. The buffer is committed only on a frame boundary, so a refresh frame never mixes old and new digits; hardware blinking of selected digits is applied on top.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scan_ctrl_mod_counter.sv | 36 +++
 rtl/seg7_scan_ctrl.sv | 98 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Constants and types shared by the seven-segment scan controller and the
// downstream decoder/driver.
package seg7_pkg;

  localparam int SEG7_DIGITS       = 4;
  localparam int SCAN_W            = 2;
  localparam int SCAN_DIV_DEFAULT  = 50000;
  localparam int BLINK_DIV_DEFAULT = 125;

  localparam logic [SEG7_DIGITS-1:0] RESET_BLANK = 4'b1111;

  // One complete set of display content, as held in both the pending and active registers
  typedef struct packed {
    logic [4*SEG7_DIGITS-1:0] hexs;
    logic [SEG7_DIGITS-1:0]   point;
    logic [SEG7_DIGITS-1:0]   blank;
    logic [SEG7_DIGITS-1:0]   blink;
  } seg7_frame_t;

  // Counter width that stays at least one bit even for a modulus of 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_mod_counter.sv
// Enabled modulo-N counter with a combinational wrap strobe that is high on
// the enabled cycle in which the count returns to zero.
module mod_counter
  import seg7_pkg::*;
#(
  parameter int N = 4,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] r_count;
  logic         w_at_top;

  assign w_at_top = (r_count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      if (w_at_top) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count = r_count;
  assign wrap  = en & w_at_top;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Digit-scan and display-update controller: new content waits in a one-entry
// pending buffer and is committed only on a frame boundary; blink is applied on top.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
  parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [4*SEG7_DIGITS-1:0] upd_hexs,
  input  logic [SEG7_DIGITS-1:0]   upd_point,
  input  logic [SEG7_DIGITS-1:0]   upd_blank,
  input  logic [SEG7_DIGITS-1:0]   upd_blink,
  output logic [SCAN_W-1:0]        Scan,
  output logic [4*SEG7_DIGITS-1:0] Hexs,
  output logic [SEG7_DIGITS-1:0]   point,
  output logic [SEG7_DIGITS-1:0]   LES,
  output logic                     frame_tick
);

  logic [cnt_width(SCAN_DIV)-1:0]  w_div_count;
  logic [cnt_width(BLINK_DIV)-1:0] w_frame_count;
  logic                            w_div_wrap;
  logic                            w_frame_wrap;
  logic                            w_boundary;
  logic                            w_accept;
  logic                            w_unused;

  logic [SCAN_W-1:0] r_scan;
  seg7_frame_t       r_pend;
  seg7_frame_t       r_act;
  logic              r_pend_full;
  logic              r_blink_phase;
  logic              r_frame_tick;

  mod_counter #(.N(SCAN_DIV)) u_digit_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (w_div_count),
    .wrap  (w_div_wrap)
  );

  mod_counter #(.N(BLINK_DIV)) u_blink_frames (
    .clk   (clk),
    .rst   (rst),
    .en    (w_boundary),
    .count (w_frame_count),
    .wrap  (w_frame_wrap)
  );

  assign w_unused   = ^{w_div_count, w_frame_count};
  assign w_boundary = w_div_wrap & (r_scan == SCAN_W'(SEG7_DIGITS - 1));
  assign upd_ready  = ~r_pend_full & ~rst;
  assign w_accept   = upd_valid & upd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan        <= '0;
      r_pend        <= '0;
      r_pend_full   <= 1'b0;
      r_act         <= '{hexs: '0, point: '0, blank: RESET_BLANK, blink: '0};
      r_blink_phase <= 1'b0;
      r_frame_tick  <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_scan <= r_scan + 1'b1;
      end
      r_frame_tick <= w_boundary;
      if (w_frame_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
      // An accept can only happen while the buffer is empty, so it never collides with a commit
      if (w_boundary && r_pend_full) begin
        r_act       <= r_pend;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend      <= '{hexs: upd_hexs, point: upd_point, blank: upd_blank, blink: upd_blink};
        r_pend_full <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < SEG7_DIGITS; gi++) begin : g_les
      assign LES[gi] = r_act.blank[gi] | (r_act.blink[gi] & r_blink_phase);
    end
  endgenerate

  assign Scan       = r_scan;
  assign Hexs       = r_act.hexs;
  assign point      = r_act.point;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV = 4 and BLINK_DIV = 2
// (16-cycle frames, blink phase flipping every 32 cycles).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_hexs = '0;
  logic [3:0]  upd_point = '0;
  logic [3:0]  upd_blank = '0;
  logic [3:0]  upd_blink = '0;
  logic [1:0]  Scan;
  logic [15:0] Hexs;
  logic [3:0]  point;
  logic [3:0]  LES;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_hexs   (upd_hexs),
    .upd_point  (upd_point),
    .upd_blank  (upd_blank),
    .upd_blink  (upd_blink),
    .Scan       (Scan),
    .Hexs       (Hexs),
    .point      (point),
    .LES        (LES),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // cyc counts rising edges since the cycle in which rst was released
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int m);
    for (int i = 0; i < 32; i++) begin
      tick();
      if (cyc % 16 == m) break;
    end
  endtask

  task automatic set_upd(input logic [15:0] h, input logic [3:0] p,
                         input logic [3:0] bl, input logic [3:0] bk);
    upd_hexs  = h;
    upd_point = p;
    upd_blank = bl;
    upd_blink = bk;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (Scan !== 2'd0) begin bad++; $display("FAIL reset_scan: got %0d want 0", Scan); end
    total++; if (Hexs !== 16'h0000) begin bad++; $display("FAIL reset_hexs: got %h want 0000", Hexs); end
    total++; if (point !== 4'b0000) begin bad++; $display("FAIL reset_point: got %b want 0000", point); end
    total++; if (LES !== 4'b1111) begin bad++; $display("FAIL reset_les: got %b want 1111", LES); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", upd_ready); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    rst = 1'b0;
    cyc = 0;
    #1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", upd_ready); end
    $display("test_reset done: total=%0d", total);
  endtask

  task automatic test_idle();
    logic [1:0] es;
    logic       et;
    for (int k = 1; k <= 48; k++) begin
      tick();
      es = 2'((cyc / 4) % 4);
      et = (cyc % 16 == 0);
      total++; if (Scan !== es) begin bad++; $display("FAIL idle_scan cyc=%0d: got %0d want %0d", cyc, Scan, es); end
      total++; if (frame_tick !== et) begin bad++; $display("FAIL idle_tick cyc=%0d: got %b want %b", cyc, frame_tick, et); end
      total++; if (LES !== 4'b1111) begin bad++; $display("FAIL idle_les cyc=%0d: got %b want 1111", cyc, LES); end
      total++; if (Hexs !== 16'h0000) begin bad++; $display("FAIL idle_hexs cyc=%0d: got %h want 0000", cyc, Hexs); end
    end
    $display("test_idle done: total=%0d", total);
  endtask

  task automatic test_mid_update();
    run_to(4);
    set_upd(16'h05AF, 4'b0101, 4'b0000, 4'b0000);
    upd_valid = 1'b1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_before: got %b want 1", upd_ready); end
    tick();
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_after: got %b want 0", upd_ready); end
    upd_valid = 1'b0;
    for (int i = 6; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        total++; if (Hexs !== 16'h0000) begin bad++; $display("FAIL mid_early_hexs cyc=%0d: got %h want 0000", cyc, Hexs); end
        total++; if (LES !== 4'b1111) begin bad++; $display("FAIL mid_early_les cyc=%0d: got %b want 1111", cyc, LES); end
      end else begin
        total++; if (Scan !== 2'd0) begin bad++; $display("FAIL mid_commit_scan: got %0d want 0", Scan); end
        total++; if (Hexs !== 16'h05AF) begin bad++; $display("FAIL mid_commit_hexs: got %h want 05af", Hexs); end
        total++; if (point !== 4'b0101) begin bad++; $display("FAIL mid_commit_point: got %b want 0101", point); end
        total++; if (LES !== 4'b0000) begin bad++; $display("FAIL mid_commit_les: got %b want 0000", LES); end
        total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL mid_commit_ready: got %b want 1", upd_ready); end
      end
    end
    $display("test_mid_update done: total=%0d", total);
  endtask

  task automatic test_back_to_back();
    set_upd(16'h1234, 4'b0001, 4'b0000, 4'b0000);
    upd_valid = 1'b1;
    tick();
    set_upd(16'h5678, 4'b1000, 4'b0010, 4'b0000);
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_first: got %b want 0", upd_ready); end
    for (int i = 2; i <= 32; i++) begin
      tick();
      if (i < 16) begin
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall cyc=%0d: got %b want 0", cyc, upd_ready); end
        total++; if (Hexs !== 16'h05AF) begin bad++; $display("FAIL b2b_old_hexs cyc=%0d: got %h want 05af", cyc, Hexs); end
      end else if (i == 16) begin
        total++; if (Hexs !== 16'h1234) begin bad++; $display("FAIL b2b_a_hexs: got %h want 1234", Hexs); end
        total++; if (point !== 4'b0001) begin bad++; $display("FAIL b2b_a_point: got %b want 0001", point); end
        total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_a: got %b want 1", upd_ready); end
      end else if (i == 17) begin
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL b2b_b_accepted: got %b want 0", upd_ready); end
        upd_valid = 1'b0;
      end else if (i < 32) begin
        total++; if (Hexs !== 16'h1234) begin bad++; $display("FAIL b2b_a_held cyc=%0d: got %h want 1234", cyc, Hexs); end
      end else begin
        total++; if (Hexs !== 16'h5678) begin bad++; $display("FAIL b2b_b_hexs: got %h want 5678", Hexs); end
        total++; if (point !== 4'b1000) begin bad++; $display("FAIL b2b_b_point: got %b want 1000", point); end
        total++; if (LES !== 4'b0010) begin bad++; $display("FAIL b2b_b_les: got %b want 0010", LES); end
      end
    end
    $display("test_back_to_back done: total=%0d", total);
  endtask

  task automatic test_boundary_accept();
    run_to(15);
    set_upd(16'h9ABC, 4'b0100, 4'b0000, 4'b0000);
    upd_valid = 1'b1;
    tick();
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL bnd_tick: got %b want 1", frame_tick); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL bnd_ready: got %b want 0", upd_ready); end
    total++; if (Hexs !== 16'h5678) begin bad++; $display("FAIL bnd_no_bypass: got %h want 5678", Hexs); end
    upd_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        total++; if (Hexs !== 16'h5678) begin bad++; $display("FAIL bnd_held cyc=%0d: got %h want 5678", cyc, Hexs); end
      end else begin
        total++; if (Hexs !== 16'h9ABC) begin bad++; $display("FAIL bnd_commit_hexs: got %h want 9abc", Hexs); end
        total++; if (point !== 4'b0100) begin bad++; $display("FAIL bnd_commit_point: got %b want 0100", point); end
        total++; if (LES !== 4'b0000) begin bad++; $display("FAIL bnd_commit_les: got %b want 0000", LES); end
      end
    end
    $display("test_boundary_accept done: total=%0d", total);
  endtask

  task automatic test_blink();
    logic [3:0] el;
    do_reset();
    tick();
    set_upd(16'h0000, 4'b0000, 4'b0100, 4'b0011);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    while (cyc < 111) begin
      tick();
      if (cyc < 16) el = 4'b1111;
      else if ((cyc / 32) % 2 == 1) el = 4'b0111;
      else el = 4'b0100;
      total++; if (LES !== el) begin bad++; $display("FAIL blink_les cyc=%0d: got %b want %b", cyc, LES, el); end
    end
    $display("test_blink done: total=%0d", total);
  endtask

  task automatic test_reset_mid();
    run_to(1);
    set_upd(16'hFFFF, 4'b1111, 4'b0000, 4'b0000);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rmid_pending: got %b want 0", upd_ready); end
    run_to(8);
    total++; if (Scan !== 2'd2) begin bad++; $display("FAIL rmid_scan_before: got %0d want 2", Scan); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (Scan !== 2'd0) begin bad++; $display("FAIL rmid_scan: got %0d want 0", Scan); end
    total++; if (LES !== 4'b1111) begin bad++; $display("FAIL rmid_les: got %b want 1111", LES); end
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready: got %b want 0", upd_ready); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rmid_tick: got %b want 0", frame_tick); end
    rst = 1'b0;
    cyc = 0;
    #1;
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL rmid_release_ready: got %b want 1", upd_ready); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++; if (Scan !== 2'((cyc / 4) % 4)) begin bad++; $display("FAIL rmid_rescan cyc=%0d: got %0d", cyc, Scan); end
      total++; if (Hexs !== 16'h0000) begin bad++; $display("FAIL rmid_discard_hexs cyc=%0d: got %h want 0000", cyc, Hexs); end
      total++; if (LES !== 4'b1111) begin bad++; $display("FAIL rmid_discard_les cyc=%0d: got %b want 1111", cyc, LES); end
    end
    $display("test_reset_mid done: total=%0d", total);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_mid_update();
    test_back_to_back();
    test_boundary_accept();
    test_blink();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
